mem_pager: RTL and testbench

Parametrised memory pager between the Z80 bus and on-chip ROM/RAM, replacing the fixed "slot 0 is write-protected ROM" routing of the single-bank design. Decodes a 128K-style paging port, maps the four 16 KB CPU slots onto ROM banks and a configurable number of RAM banks, selects the active screen page for the ULA, and inserts a configurable number of wait cycles per memory access. Sits between `z80` and `memory` in the board top level.

---
 rtl/mem_pager.sv | 75 +++++++
 tb/tb_mem_pager.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_pager.sv
// mem_pager: Z80 paging port decode, 16 KB slot map onto ROM/RAM banks, and access wait-state FSM.
// Optional feature: define MEM_PAGER_LOCK_EN so that page_reg[5]=1 blocks further port writes until reset.
module mem_pager #(
  parameter int BANK_BITS   = 3,
  parameter int ROM_BITS    = 1,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           cpu_addr,
  input  logic [7:0]            cpu_dout,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_iowe,
  output logic                  cpu_ready,
  output logic                  rom_sel,
  output logic [14+ROM_BITS-1:0]  rom_addr,
  output logic [14+BANK_BITS-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  vid_page,
  output logic [7:0]            page_reg
);
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] slot;
  logic locked, port_wr;
  logic [BANK_BITS-1:0] ram_bank;
  assign slot = cpu_addr[15:14];
`ifdef MEM_PAGER_LOCK_EN
  assign locked = page_reg[5];
`else
  assign locked = 1'b0;
`endif
  assign port_wr = cpu_iowe & ~cpu_addr[15] & ~cpu_addr[1] & ~locked;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      page_reg <= '0;
      state    <= IDLE;
      cnt      <= '0;
    end else begin
      if (port_wr) page_reg <= cpu_dout;
      state <= state_n;
      cnt   <= cnt_n;
    end
  // WAIT leaves for HOLD once the incremented count hits WAIT_CYCLES, giving WAIT_CYCLES+1 cycles of latency
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (cpu_req && WAIT_CYCLES > 0) begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT: if (!cpu_req) state_n = IDLE;
            else begin
              cnt_n   = cnt + 4'd1;
              state_n = (cnt + 4'd1 == WC) ? HOLD : WAIT;
            end
      HOLD: if (!cpu_req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign cpu_ready = (state == HOLD) || (state == IDLE && WAIT_CYCLES == 0);
  // extra RAM bank bits come from page_reg[6] then page_reg[7]; ROM bit 1 is page_reg[7]
  assign ram_bank = (slot == 2'd1) ? BANK_BITS'(5) :
                    (slot == 2'd2) ? BANK_BITS'(2) :
                    BANK_BITS'({page_reg[7:6], page_reg[2:0]});
  assign rom_sel  = (slot == 2'd0);
  assign rom_addr = {ROM_BITS'({page_reg[7], page_reg[4]}), cpu_addr[13:0]};
  assign ram_addr = {ram_bank, cpu_addr[13:0]};
  assign ram_we   = cpu_req & cpu_we & cpu_ready & ~rom_sel;
  assign vid_page = page_reg[3];
endmodule

// File: tb/tb_mem_pager.sv
// tb_mem_pager: scoreboard bench driving two pager configurations (3-bit/no-wait and 5-bit/2-ROM-bit/3-wait).
module tb_mem_pager;
  logic clock = 0, reset = 1;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_dout = '0;
  logic cpu_we = 0, cpu_iowe = 0, req0 = 0, req1 = 0;
  logic ready0, rom_sel0, ram_we0, vid0;
  logic [14:0] rom_addr0;
  logic [16:0] ram_addr0;
  logic [7:0] pg0;
  logic ready1, rom_sel1, ram_we1, vid1;
  logic [15:0] rom_addr1;
  logic [18:0] ram_addr1;
  logic [7:0] pg1;
  int checks = 0, errors = 0;

  typedef struct {
    string name;
    logic rom_sel;
    logic [15:0] rom_addr;
    logic chk_ram;
    logic [18:0] ram_addr;
    logic ram_we;
    logic vid;
    logic [7:0] pg;
  } exp_t;
  exp_t q0[$], q1[$];

  always #5 clock = ~clock;

  mem_pager dut0 (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_req(req0), .cpu_we(cpu_we), .cpu_iowe(cpu_iowe), .cpu_ready(ready0),
    .rom_sel(rom_sel0), .rom_addr(rom_addr0), .ram_addr(ram_addr0), .ram_we(ram_we0),
    .vid_page(vid0), .page_reg(pg0));

  mem_pager #(.BANK_BITS(5), .ROM_BITS(2), .WAIT_CYCLES(3)) dut1 (
    .clock(clock), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_req(req1), .cpu_we(cpu_we), .cpu_iowe(cpu_iowe), .cpu_ready(ready1),
    .rom_sel(rom_sel1), .rom_addr(rom_addr1), .ram_addr(ram_addr1), .ram_we(ram_we1),
    .vid_page(vid1), .page_reg(pg1));

  function automatic exp_t mk(string n, logic rs, logic [15:0] ra, logic cr, logic [18:0] wa,
                              logic we, logic vd, logic [7:0] pg);
    exp_t e;
    e.name = n; e.rom_sel = rs; e.rom_addr = ra; e.chk_ram = cr; e.ram_addr = wa;
    e.ram_we = we; e.vid = vd; e.pg = pg;
    return e;
  endfunction

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic cmp(input exp_t e, input logic rs, input logic [15:0] ra, input logic [18:0] wa,
                     input logic we, input logic vd, input logic [7:0] pg);
    checks++;
    if ({rs, ra, we, vd, pg} !== {e.rom_sel, e.rom_addr, e.ram_we, e.vid, e.pg} ||
        (e.chk_ram && wa !== e.ram_addr)) begin
      errors++;
      $display("FAIL %s: got rom_sel=%b rom_addr=%h ram_addr=%h ram_we=%b vid=%b pg=%h expected rom_sel=%b rom_addr=%h ram_addr=%h ram_we=%b vid=%b pg=%h",
               e.name, rs, ra, wa, we, vd, pg,
               e.rom_sel, e.rom_addr, e.ram_addr, e.ram_we, e.vid, e.pg);
    end
  endtask

  always @(negedge clock) begin
    if (req0 && ready0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon0: unexpected ready with empty scoreboard");
      end else cmp(q0.pop_front(), rom_sel0, 16'(rom_addr0), 19'(ram_addr0), ram_we0, vid0, pg0);
    end
    if (req1 && ready1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon1: unexpected ready with empty scoreboard");
      end else cmp(q1.pop_front(), rom_sel1, rom_addr1, ram_addr1, ram_we1, vid1, pg1);
    end
  end

  task automatic access(input int k, input logic [15:0] a, input logic we, input exp_t e);
    int n = 0;
    logic early = 0;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clock); #1;
    cpu_addr = a; cpu_we = we;
    if (k == 0) req0 = 1; else req1 = 1;
    @(negedge clock);
    while (!(k == 0 ? ready0 : ready1) && n < 20) begin
      early |= (k == 0 ? ram_we0 : ram_we1);
      n++;
      @(negedge clock);
    end
    check({e.name, " latency"}, n, k == 0 ? 0 : 4);
    check({e.name, " ram_we before ready"}, 32'(early), 0);
    @(posedge clock); #1;
    req0 = 0; req1 = 0; cpu_we = 0;
  endtask

  task automatic io_write(input int k, input logic [15:0] a, input logic [7:0] d, input logic [7:0] old);
    @(posedge clock); #1;
    cpu_addr = a; cpu_dout = d; cpu_iowe = 1;
    @(negedge clock);
    check("page_reg during strobe", k == 0 ? pg0 : pg1, old);
    @(posedge clock); #1;
    cpu_iowe = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset pg0", pg0, 0);
    check("reset vid0", vid0, 0);
    check("reset ready0", ready0, 1);
    check("reset ready1", ready1, 0);
    check("reset ram_we0", ram_we0, 0);
    do_reset();
    access(0, 16'h0000, 0, mk("d0 rd 0000", 1, 16'h0000, 0, 0, 0, 0, 8'h00));
    access(0, 16'hC123, 0, mk("d0 rd C123", 0, 16'h0123, 1, 19'h00123, 0, 0, 8'h00));
    io_write(0, 16'h7FFD, 8'h1F, 8'h00);
    access(0, 16'hC000, 0, mk("d0 rd C000 pg1F", 0, 16'h4000, 1, 19'h1C000, 0, 1, 8'h1F));
    access(0, 16'h1234, 1, mk("d0 wr 1234 rom", 1, 16'h5234, 0, 0, 0, 1, 8'h1F));
    access(0, 16'h4000, 1, mk("d0 wr 4000", 0, 16'h4000, 1, 19'h14000, 1, 1, 8'h1F));
    access(0, 16'h8005, 1, mk("d0 wr 8005", 0, 16'h4005, 1, 19'h08005, 1, 1, 8'h1F));
    io_write(0, 16'h7FFF, 8'h00, 8'h1F);
    io_write(0, 16'hFFFD, 8'h00, 8'h1F);
    access(0, 16'hC000, 0, mk("d0 no decode", 0, 16'h4000, 1, 19'h1C000, 0, 1, 8'h1F));
    io_write(0, 16'h7FFD, 8'h20, 8'h1F);
    io_write(0, 16'h7FFD, 8'h07, 8'h20);
`ifdef MEM_PAGER_LOCK_EN
    access(0, 16'hC000, 0, mk("d0 locked", 0, 16'h0000, 1, 19'h00000, 0, 0, 8'h20));
`else
    access(0, 16'hC000, 0, mk("d0 unlocked", 0, 16'h0000, 1, 19'h1C000, 0, 0, 8'h07));
`endif
    do_reset();
    access(1, 16'hC123, 0, mk("d1 rd C123", 0, 16'h0123, 1, 19'h00123, 0, 0, 8'h00));
    io_write(1, 16'h7FFD, 8'hC3, 8'h00);
    access(1, 16'hC010, 0, mk("d1 rd C010 pgC3", 0, 16'h8010, 1, 19'h6C010, 0, 0, 8'hC3));
    access(1, 16'h4001, 1, mk("d1 wr 4001", 0, 16'h8001, 1, 19'h14001, 1, 0, 8'hC3));
    access(1, 16'h0001, 1, mk("d1 wr 0001 rom", 1, 16'h8001, 0, 0, 0, 0, 8'hC3));
    io_write(1, 16'h7FFD, 8'h98, 8'hC3);
    access(1, 16'hC000, 0, mk("d1 rd C000 pg98", 0, 16'hC000, 1, 19'h40000, 0, 1, 8'h98));
    @(posedge clock); #1;
    cpu_addr = 16'h4000; cpu_we = 1; req1 = 1;
    repeat (2) begin
      @(negedge clock);
      check("drop ready", ready1, 0);
      check("drop ram_we", ram_we1, 0);
    end
    @(posedge clock); #1;
    req1 = 0; cpu_we = 0;
    @(negedge clock);
    check("after drop ram_we", ram_we1, 0);
    access(1, 16'h8000, 0, mk("d1 after drop", 0, 16'hC000, 1, 19'h08000, 0, 1, 8'h98));
    @(posedge clock); #1;
    cpu_addr = 16'h4000; cpu_we = 1; req1 = 1;
    repeat (2) @(negedge clock);
    reset = 1;
    #1;
    check("reset in wait ready", ready1, 0);
    check("reset in wait pg", pg1, 0);
    check("reset in wait ram_we", ram_we1, 0);
    @(posedge clock); #1;
    req1 = 0; cpu_we = 0; reset = 0;
    access(1, 16'hC000, 0, mk("d1 after reset", 0, 16'h0000, 1, 19'h00000, 0, 0, 8'h00));
    check("q0 drained", q0.size(), 0);
    check("q1 drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
